mem_bus_ctrl: RTL and testbench
===============================

// Module: mem_bus_ctrl
// PURPOSE
// - Memory-side controller for the sequencer's control bus: accepts one ROM/RAM access request, drives the memory array, returns read data.
// - Sits directly downstream of the sequencer, which issues dev/opaddr/ldstr requests; this block completes them with read data or an error.
// - Single outstanding transaction; fixed, parameterised wait states; illegal requests get an error response.
// PARAMETERS
// - DATA_W       14  data/instruction word width (opcode field at [13:10])
// - ADDR_W        4  address width (opaddr)
// - WAIT_STATES   0  extra cycles between memory enable and data capture (0..15)
// PORTS
// - clock      in   1       system clock; all logic on rising edge
// - reset      in   1       synchronous, active-high reset
// - req_valid  in   1       request present
// - req_ready  out  1       block can accept a request (IDLE only)
// - req_dev    in   2       target device: 00 none, 01 ROM, 10 RAM, 11 reserved
// - req_addr   in   ADDR_W  word address
// - req_ldstr  in   1       0 = load (read), 1 = store (write)
// - req_wdata  in   DATA_W  store data
// - rsp_valid  out  1       one-cycle response strobe
// - rsp_data   out  DATA_W  load data; 0 on store or error; held until next rsp_valid
// - rsp_err    out  1       error flag, qualified by rsp_valid
// - rom_en     out  1       ROM read enable, one-cycle pulse
// - rom_addr   out  ADDR_W  ROM address
// - rom_rdata  in   DATA_W  ROM read data, valid 1+WAIT_STATES cycles after rom_en
// - ram_en     out  1       RAM enable, one-cycle pulse
// - ram_we     out  1       RAM write enable, only together with ram_en
// - ram_addr   out  ADDR_W  RAM address
// - ram_wdata  out  DATA_W  RAM write data
// - ram_rdata  in   DATA_W  RAM read data, valid 1+WAIT_STATES cycles after ram_en
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1; rsp_valid, rsp_err, rom_en, ram_en, ram_we=0; rsp_data, addresses, wdata=0.
// - Reset wins over everything, including mid-transaction: no further enable pulses, no response for the aborted request.
// - Accept on req_valid & req_ready (cycle T). Register dev/addr/ldstr/wdata; req_ready drops in T+1.
// - FSM:
//   - IDLE -> ACCESS on a legal accept.
//   - IDLE -> RESP on an illegal accept.
//   - ACCESS -> WAIT if WAIT_STATES>0, else -> CAPTURE.
//   - WAIT -> CAPTURE after WAIT_STATES cycles.
//   - CAPTURE -> RESP.
//   - RESP -> IDLE.
// - Legal requests: ROM load, RAM load, RAM store.
// - Illegal requests: dev 00 or 11, and ROM store. These generate no memory enable; rsp_valid=1, rsp_err=1, rsp_data=0 in cycle T+1.
// - ACCESS (T+1): exactly one of rom_en/ram_en high for one cycle; address from the registered request; ram_we=ldstr for RAM.
// - CAPTURE (T+2+W): load registers rom_rdata/ram_rdata; store leaves the data register at 0.
// - RESP (T+3+W): rsp_valid=1 for exactly one cycle, rsp_err=0.
// - Latency: accept-to-rsp_valid is 3+WAIT_STATES for legal requests, 1 for illegal. Minimum accept spacing is 4+W (legal) or 2 (illegal).
// - rsp_data/rsp_err are registered and hold their last value until the next response.
// - req_* inputs are ignored outside IDLE, and ignored when req_valid=0.
// - Wait counter width is 4 bits; counts WAIT_STATES-1 down to 0; no wrap because it is reloaded on every ACCESS.
// - Outputs are all registered; no combinational path from req_* to memory pins.
// STRUCTURE
// - Shared package cpu_bus_pkg provides:
//   - typedef enum logic [1:0] dev_e {DEV_NONE, DEV_ROM, DEV_RAM, DEV_RSVD}
//   - LDR_OP=0, STR_OP=1 constants for ldstr
//   - bus_state_e {IDLE, ACCESS, WAIT, CAPTURE, RESP}
// - The same dev_e encoding is used by the sequencer.
// - One sub-module: bus_wait_timer (load/decrement/zero flag, 4-bit), instantiated for the WAIT state.
// TESTING
// - W=0, ROM load addr 4'h3, rom holds 14'h0A5F; accept at T -> rom_en pulse at T+1, rsp_valid at T+3, rsp_data=14'h0A5F, rsp_err=0.
// - W=2, RAM store addr 4'h7 data 14'h1234, then RAM load addr 4'h7 -> ram_en&ram_we pulse once; store rsp at T+5 with data 0; load returns 14'h1234.
// - ROM store (dev=01, ldstr=1), and dev=11 load -> no rom_en/ram_en ever; rsp_valid at T+1, rsp_err=1, rsp_data=0.
// - req_valid held high with changing addr during ACCESS/WAIT -> ignored; req_ready=0 until IDLE; only the first request is served.
// - Assert reset during WAIT (W=3) -> next cycle IDLE, req_ready=1, all enables 0, no rsp_valid; a fresh ROM load then completes normally.
// - Back-to-back legal loads with req_valid held high -> accepts spaced exactly 4+W cycles apart; rsp_data holds between strobes.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared control-bus definitions for the sequencer and the memory-side bus controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: device encoding, load/store opcode values, bus FSM states, request legality helper.
package cpu_bus_pkg;

  // Device select; the same encoding is produced by the sequencer.
  typedef enum logic [1:0] {
    DEV_NONE = 2'b00,
    DEV_ROM  = 2'b01,
    DEV_RAM  = 2'b10,
    DEV_RSVD = 2'b11
  } dev_e;

  localparam logic LDR_OP = 1'b0;
  localparam logic STR_OP = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    CAPTURE,
    RESP
  } bus_state_e;

  // ROM is read-only; NONE and RSVD never reach a memory.
  function automatic logic is_legal(input dev_e dev, input logic ldstr);
    return (dev == DEV_RAM) || ((dev == DEV_ROM) && (ldstr == LDR_OP));
  endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Wait-state down-counter for the memory bus controller.
// Latency: load takes effect on the next edge; zero is combinational from the count.
// Backpressure: none; load has priority over decrement.
// Ports: clock, reset (sync, active-high), load/load_val (preset), dec (count down), zero (count is 0).
module bus_wait_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side controller for the sequencer control bus: one ROM/RAM access at a time, read data or error back.
// Latency: accept to rsp_valid is 3+WAIT_STATES cycles for legal requests, 1 cycle for illegal ones.
// Backpressure: req_ready is high only in IDLE; req_* is ignored while a transaction is in flight.
// Ports: clock/reset (sync, active-high); req_valid/req_ready/req_dev/req_addr/req_ldstr/req_wdata request side;
//        rsp_valid/rsp_data/rsp_err response side; rom_en/rom_addr/rom_rdata ROM port;
//        ram_en/ram_we/ram_addr/ram_wdata/ram_rdata RAM port. All outputs are registered.
module mem_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int DATA_W      = 14,
  parameter int ADDR_W      = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_dev,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ldstr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // The timer holds WAIT_STATES-1 on entry to WAIT so WAIT lasts exactly WAIT_STATES cycles.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  bus_state_e state, state_nxt;
  dev_e       dev_q;
  logic       ldstr_q;
  logic       accept;
  logic       legal;
  logic       tmr_load;
  logic       tmr_dec;
  logic       tmr_zero;

  assign accept = req_valid && (state == IDLE);
  assign legal  = is_legal(dev_e'(req_dev), req_ldstr);

  bus_wait_timer u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (WAIT_LOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = legal ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        tmr_load  = 1'b1;
        state_nxt = (WAIT_STATES > 0) ? WAIT : CAPTURE;
      end
      WAIT: begin
        if (tmr_zero) begin
          state_nxt = CAPTURE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CAPTURE: state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory pins and response are launched from registers so nothing on req_* reaches a pin
  // combinationally. The enables are set on the accept edge, which puts them in the ACCESS cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      dev_q     <= DEV_NONE;
      ldstr_q   <= LDR_OP;
    end else begin
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= 1'b0;
      rom_en    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;

      if (accept) begin
        dev_q   <= dev_e'(req_dev);
        ldstr_q <= req_ldstr;
        if (legal) begin
          if (dev_e'(req_dev) == DEV_ROM) begin
            rom_en   <= 1'b1;
            rom_addr <= req_addr;
          end else begin
            ram_en    <= 1'b1;
            ram_we    <= req_ldstr;
            ram_addr  <= req_addr;
            ram_wdata <= req_wdata;
          end
        end else begin
          // Illegal requests are answered straight away without touching either memory.
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
        end
      end

      // Capture read data and raise the strobe on the same edge so RESP sees both together.
      if (state == CAPTURE) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b0;
        if (ldstr_q == STR_OP) begin
          rsp_data <= '0;
        end else if (dev_q == DEV_ROM) begin
          rsp_data <= rom_rdata;
        end else begin
          rsp_data <= ram_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: three instances (WAIT_STATES 0, 2, 3) share the request inputs,
// each with its own RAM model and a common ROM image; every check names the instance it targets.
module tb_mem_bus_ctrl;
  import cpu_bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_dev;
  logic [3:0]  req_addr;
  logic        req_ldstr;
  logic [13:0] req_wdata;

  logic        req_ready_a [3];
  logic        rsp_valid_a [3];
  logic        rsp_err_a   [3];
  logic        rom_en_a    [3];
  logic        ram_en_a    [3];
  logic        ram_we_a    [3];
  logic [13:0] rsp_data_a  [3];
  logic [13:0] rom_rdata_a [3];
  logic [13:0] ram_rdata_a [3];
  logic [13:0] ram_wdata_a [3];
  logic [3:0]  rom_addr_a  [3];
  logic [3:0]  ram_addr_a  [3];

  logic [13:0] rom [16];
  logic [13:0] ram [3][16];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_ctrl #(
      .DATA_W      (14),
      .ADDR_W      (4),
      .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clock     (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready_a[g]),
      .req_dev   (req_dev),
      .req_addr  (req_addr),
      .req_ldstr (req_ldstr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid_a[g]),
      .rsp_data  (rsp_data_a[g]),
      .rsp_err   (rsp_err_a[g]),
      .rom_en    (rom_en_a[g]),
      .rom_addr  (rom_addr_a[g]),
      .rom_rdata (rom_rdata_a[g]),
      .ram_en    (ram_en_a[g]),
      .ram_we    (ram_we_a[g]),
      .ram_addr  (ram_addr_a[g]),
      .ram_wdata (ram_wdata_a[g]),
      .ram_rdata (ram_rdata_a[g])
    );

    assign rom_rdata_a[g] = rom[rom_addr_a[g]];
    assign ram_rdata_a[g] = ram[g][ram_addr_a[g]];

    always @(posedge clk) begin
      if (ram_en_a[g] && ram_we_a[g]) ram[g][ram_addr_a[g]] <= ram_wdata_a[g];
    end
  end

  function automatic int ws(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop req_valid and let every instance drain back to IDLE.
  task automatic wait_idle();
    logic all_rdy;
    req_valid = 1'b0;
    all_rdy   = 1'b0;
    for (int i = 0; i < 50; i++) begin
      all_rdy = req_ready_a[0] && req_ready_a[1] && req_ready_a[2];
      if (all_rdy) break;
      step();
    end
    chk("idle_timeout", 32'(all_rdy), 32'd1);
  endtask

  // Issue one request in the current cycle (T) and check instance k cycle by cycle through
  // the response and the following IDLE cycle. With hold=1 req_valid stays high and req_addr
  // keeps changing while busy; the task returns in the IDLE cycle with req_valid still high.
  task automatic do_req(input int k, input logic [1:0] dev, input logic [3:0] addr,
                        input logic ldstr, input logic [13:0] wdata,
                        input logic [13:0] exp_data, input logic exp_err, input logic hold);
    int          lat;
    logic        legal;
    logic        is_rom;
    logic        is_ram;
    logic [13:0] prev;
    legal  = ((dev == 2'b01) && !ldstr) || (dev == 2'b10);
    is_rom = legal && (dev == 2'b01);
    is_ram = legal && (dev == 2'b10);
    lat    = legal ? 3 + ws(k) : 1;
    prev   = rsp_data_a[k];
    chk($sformatf("rdy_accept[%0d]", k), 32'(req_ready_a[k]), 32'd1);
    req_valid = 1'b1;
    req_dev   = dev;
    req_addr  = addr;
    req_ldstr = ldstr;
    req_wdata = wdata;
    for (int n = 1; n <= lat; n++) begin
      step();
      req_valid = hold;
      if (hold) req_addr = req_addr + 4'd1;
      chk($sformatf("rdy_busy[%0d] c%0d", k, n), 32'(req_ready_a[k]), 32'd0);
      chk($sformatf("rom_en[%0d] c%0d", k, n), 32'(rom_en_a[k]), 32'(n == 1 && is_rom));
      chk($sformatf("ram_en[%0d] c%0d", k, n), 32'(ram_en_a[k]), 32'(n == 1 && is_ram));
      chk($sformatf("ram_we[%0d] c%0d", k, n), 32'(ram_we_a[k]), 32'(n == 1 && is_ram && ldstr));
      chk($sformatf("rsp_vld[%0d] c%0d", k, n), 32'(rsp_valid_a[k]), 32'(n == lat));
      if (n == 1 && is_rom) chk($sformatf("rom_addr[%0d]", k), 32'(rom_addr_a[k]), 32'(addr));
      if (n == 1 && is_ram) chk($sformatf("ram_addr[%0d]", k), 32'(ram_addr_a[k]), 32'(addr));
      if (n == 1 && is_ram && ldstr) chk($sformatf("ram_wdata[%0d]", k), 32'(ram_wdata_a[k]), 32'(wdata));
      if (n < lat) begin
        chk($sformatf("rsp_hold[%0d] c%0d", k, n), 32'(rsp_data_a[k]), 32'(prev));
      end else begin
        chk($sformatf("rsp_data[%0d]", k), 32'(rsp_data_a[k]), 32'(exp_data));
        chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err_a[k]), 32'(exp_err));
      end
    end
    step();
    chk($sformatf("rsp_vld_end[%0d]", k), 32'(rsp_valid_a[k]), 32'd0);
    chk($sformatf("rdy_end[%0d]", k), 32'(req_ready_a[k]), 32'd1);
    chk($sformatf("rsp_keep[%0d]", k), 32'(rsp_data_a[k]), 32'(exp_data));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rom[i] = 14'(i * 333 + 257);
      for (int j = 0; j < 3; j++) ram[j][i] = 14'h0000;
    end
    rom[3] = 14'h0A5F;

    reset     = 1'b1;
    req_valid = 1'b0;
    req_dev   = 2'b00;
    req_addr  = 4'h0;
    req_ldstr = 1'b0;
    req_wdata = 14'h0000;
    repeat (3) step();

    // Reset values on every instance.
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_rdy[%0d]", k), 32'(req_ready_a[k]), 32'd1);
      chk($sformatf("rst_vld[%0d]", k), 32'(rsp_valid_a[k]), 32'd0);
      chk($sformatf("rst_err[%0d]", k), 32'(rsp_err_a[k]), 32'd0);
      chk($sformatf("rst_data[%0d]", k), 32'(rsp_data_a[k]), 32'd0);
      chk($sformatf("rst_en[%0d]", k), 32'({rom_en_a[k], ram_en_a[k], ram_we_a[k]}), 32'd0);
      chk($sformatf("rst_addr[%0d]", k), 32'({rom_addr_a[k], ram_addr_a[k]}), 32'd0);
      chk($sformatf("rst_wdata[%0d]", k), 32'(ram_wdata_a[k]), 32'd0);
    end
    reset = 1'b0;
    step();

    // W=0 ROM load: enable at T+1, response at T+3.
    wait_idle();
    do_req(0, DEV_ROM, 4'h3, LDR_OP, 14'h0000, 14'h0A5F, 1'b0, 1'b0);

    // Illegal requests on W=0: ROM store, reserved device, no device.
    wait_idle();
    do_req(0, DEV_ROM, 4'h2, STR_OP, 14'h3FFF, 14'h0000, 1'b1, 1'b0);
    wait_idle();
    do_req(0, DEV_RSVD, 4'h5, LDR_OP, 14'h0000, 14'h0000, 1'b1, 1'b0);
    wait_idle();
    do_req(0, DEV_NONE, 4'h1, LDR_OP, 14'h0000, 14'h0000, 1'b1, 1'b0);

    // W=2 RAM store then load back.
    wait_idle();
    do_req(1, DEV_RAM, 4'h7, STR_OP, 14'h1234, 14'h0000, 1'b0, 1'b0);
    wait_idle();
    do_req(1, DEV_RAM, 4'h7, LDR_OP, 14'h0000, 14'h1234, 1'b0, 1'b0);

    // W=2 request held with changing address, then the held request is taken exactly 4+W later.
    wait_idle();
    do_req(1, DEV_ROM, 4'h3, LDR_OP, 14'h0000, 14'h0A5F, 1'b0, 1'b1);
    do_req(1, DEV_ROM, 4'h9, LDR_OP, 14'h0000, rom[9], 1'b0, 1'b0);

    // W=0 back-to-back loads with req_valid held: ROM then RAM.
    wait_idle();
    do_req(0, DEV_ROM, 4'h5, LDR_OP, 14'h0000, rom[5], 1'b0, 1'b1);
    do_req(0, DEV_RAM, 4'h4, LDR_OP, 14'h0000, 14'h0000, 1'b0, 1'b0);

    // W=3: reset during WAIT aborts without response; a fresh load then completes.
    wait_idle();
    req_valid = 1'b1;
    req_dev   = DEV_ROM;
    req_addr  = 4'h6;
    req_ldstr = LDR_OP;
    step();
    req_valid = 1'b0;
    chk("abort_rom_en", 32'(rom_en_a[2]), 32'd1);
    step();
    step();
    chk("abort_in_wait", 32'({rom_en_a[2], rsp_valid_a[2], req_ready_a[2]}), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_rdy", 32'(req_ready_a[2]), 32'd1);
    chk("abort_en", 32'({rom_en_a[2], ram_en_a[2], ram_we_a[2]}), 32'd0);
    chk("abort_vld", 32'(rsp_valid_a[2]), 32'd0);
    chk("abort_data", 32'(rsp_data_a[2]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("abort_quiet c%0d", i), 32'({rom_en_a[2], rsp_valid_a[2]}), 32'd0);
    end
    do_req(2, DEV_ROM, 4'h6, LDR_OP, 14'h0000, rom[6], 1'b0, 1'b0);

    wait_idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
